// File: rtl/sobel_frame_streamer_if.sv
// sobel_frame_streamer_if: control, frame-memory read bus and pixel stream of the frame streamer
//  master (streamer): in start_i, mem_data_i; out mem_re_o, mem_addr_o, data_o, we_o, busy_o, done_o
//  slave  (system):   the same signals with the directions reversed
interface sobel_frame_streamer_if #(
  parameter int ADDR_W = 19
) ();
  logic              start_i;
  logic              mem_re_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [7:0]        mem_data_i;
  logic [7:0]        data_o;
  logic              we_o;
  logic              busy_o;
  logic              done_o;
  modport master (
    input  start_i, mem_data_i,
    output mem_re_o, mem_addr_o, data_o, we_o, busy_o, done_o
  );
  modport slave (
    output start_i, mem_data_i,
    input  mem_re_o, mem_addr_o, data_o, we_o, busy_o, done_o
  );
endinterface

// File: rtl/sobel_frame_streamer.sv
// sobel_frame_streamer: reads a ROWS x COLS frame in raster order and streams it as data_o/we_o
//  clk, rst (sync, active-high); bus: sobel_frame_streamer_if master
//   start_i starts a frame from IDLE; mem_re_o/mem_addr_o read the frame memory, whose data returns on
//   mem_data_i one cycle later; data_o/we_o carry the pixels; busy_o marks a frame; done_o pulses at its end
module sobel_frame_streamer #(
  parameter int ROWS     = 480,
  parameter int COLS     = 640,
  parameter int LINE_GAP = 0,
  parameter int ADDR_W   = 19
) (
  input logic                  clk,
  input logic                  rst,
  sobel_frame_streamer_if.master bus
);
  localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
  localparam int CW = COLS > 1 ? $clog2(COLS) : 1;
  localparam int GW = LINE_GAP > 2 ? $clog2(LINE_GAP) : 1;
  typedef enum logic [2:0] {IDLE, STREAM, GAP, DRAIN, DONE} state_t;
  state_t            state_q, state_d;
  logic [RW-1:0]     row_q, row_d;
  logic [CW-1:0]     col_q, col_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [GW-1:0]     cnt_q, cnt_d;
  logic              re_q, re_d, re_d1_q, re_d1_d, we_q, we_d, busy_q, busy_d, done_q, done_d;
  logic [7:0]        data_q, data_d;
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    re_d    = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    re_d1_d = re_q;
    we_d    = re_d1_q;
    data_d  = re_d1_q ? bus.mem_data_i : data_q;
    case (state_q)
      IDLE: begin
        addr_d = '0;
        if (bus.start_i) begin
          state_d = STREAM;
          row_d   = '0;
          col_d   = '0;
          re_d    = 1'b1;
          busy_d  = 1'b1;
        end
      end
      STREAM: begin
        if (col_q == CW'(COLS - 1)) begin
          col_d = '0;
          if (row_q == RW'(ROWS - 1)) begin
            // last pixel: address stays at N-1, drain counter covers the two pipeline stages
            state_d = DRAIN;
            cnt_d   = GW'(1);
          end else begin
            row_d  = row_q + 1'b1;
            addr_d = addr_q + 1'b1;
            if (LINE_GAP > 0) begin
              state_d = GAP;
              cnt_d   = GW'(LINE_GAP - 1);
            end else begin
              re_d = 1'b1;
            end
          end
        end else begin
          col_d  = col_q + 1'b1;
          addr_d = addr_q + 1'b1;
          re_d   = 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = STREAM;
          re_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DRAIN: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          addr_d  = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      re_q    <= 1'b0;
      re_d1_q <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      re_q    <= re_d;
      re_d1_q <= re_d1_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      data_q  <= data_d;
    end
  end
  assign bus.mem_re_o   = re_q;
  assign bus.mem_addr_o = addr_q;
  assign bus.data_o     = data_q;
  assign bus.we_o       = we_q;
  assign bus.busy_o     = busy_q;
  assign bus.done_o     = done_q;
endmodule

// File: tb/tb_sobel_frame_streamer.sv
// tb_sobel_frame_streamer: randomized frames on four geometries checked against a timeline model
module tb_sobel_frame_streamer;
  localparam int AW = 8;
  localparam int RS[4] = '{3, 3, 1, 3};
  localparam int CS[4] = '{4, 4, 1, 1};
  localparam int GS[4] = '{0, 2, 0, 1};
  localparam int DL[4] = '{15, 19, 4, 8};
  localparam int PL[4] = '{12, 12, 1, 3};
  logic clk;
  int   n_cmp = 0;
  int   n_bad = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input int g, input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL cfg%0d %s: got %0d expected %0d at %0t", g, nm, act, exp, $time);
    end
  endtask
  for (genvar g = 0; g < 4; g++) begin : c
    localparam int R  = RS[g];
    localparam int C  = CS[g];
    localparam int G  = GS[g];
    localparam int N  = R * C;
    localparam int TD = N + 3 + (R - 1) * G;
    logic       rst;
    logic [7:0] mem [N];
    bit         fin = 0;
    bit         live = 0;
    int         t = 0;
    logic [7:0] ed = 8'h00;
    sobel_frame_streamer_if #(.ADDR_W(AW)) bus ();
    sobel_frame_streamer #(.ROWS(R), .COLS(C), .LINE_GAP(G), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .bus(bus.master)
    );
    always @(posedge clk)
      if (bus.mem_re_o) bus.mem_data_i <= (int'(bus.mem_addr_o) < N) ? mem[bus.mem_addr_o] : 8'h00;
    // pixel read in frame cycle t (cycle 1 follows the start edge), or -1
    function automatic int pix(input int tt);
      int u;
      u = tt - 1;
      if (tt < 1 || u % (C + G) >= C || u / (C + G) >= R) return -1;
      return (u / (C + G)) * C + u % (C + G);
    endfunction
    always @(posedge clk) begin
      live = 1;
      if (rst) begin
        t  = 0;
        ed = 8'h00;
      end else begin
        t = (t == 0) ? int'(bus.start_i) : (t == TD ? 0 : t + 1);
        if (pix(t - 2) >= 0) ed = mem[pix(t - 2)];
      end
    end
    always @(negedge clk) begin
      if (live) begin
        chk(g, "mem_re", int'(bus.mem_re_o), int'(pix(t) >= 0));
        if (pix(t) >= 0) chk(g, "mem_addr", int'(bus.mem_addr_o), pix(t));
        else if (t == 0) chk(g, "idle_addr", int'(bus.mem_addr_o), 0);
        chk(g, "addr_max", int'(int'(bus.mem_addr_o) <= N - 1), 1);
        chk(g, "we", int'(bus.we_o), int'(pix(t - 2) >= 0));
        chk(g, "data", int'(bus.data_o), int'(ed));
        chk(g, "busy", int'(bus.busy_o), int'(t >= 1 && t < TD));
        chk(g, "done", int'(bus.done_o), int'(t == TD));
      end
    end
    initial begin
      int first_we, done_at, pulses, kill;
      logic [7:0] first_data;
      rst = 1'b1;
      bus.start_i = 1'b0;
      for (int a = 0; a < N; a++) mem[a] = (g == 2) ? 8'hA5 : 8'(a);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      bus.start_i = 1'b1;
      @(posedge clk);
      first_we = 0;
      done_at = 0;
      pulses = 0;
      first_data = 8'h00;
      // start held high through the whole frame, dropped in the first idle cycle
      for (int cy = 1; cy <= TD + 3; cy++) begin
        @(negedge clk);
        if (bus.we_o && first_we == 0) begin
          first_we = cy;
          first_data = bus.data_o;
        end
        pulses += int'(bus.we_o);
        if (bus.done_o) done_at = cy;
        if (cy == TD + 1) bus.start_i = 1'b0;
      end
      chk(g, "first_we_cycle", first_we, 3);
      chk(g, "first_data", int'(first_data), (g == 2) ? 8'hA5 : 0);
      chk(g, "done_cycle", done_at, DL[g]);
      chk(g, "we_pulses", pulses, PL[g]);
      @(posedge clk);
      #1;
      for (int i = 0; i < 10; i++) begin
        for (int a = 0; a < N; a++) mem[a] = 8'($urandom);
        kill = (i == 0) ? ((TD > 6) ? 6 : 1) : (($urandom_range(0, 2) == 0) ? int'($urandom_range(1, TD)) : 0);
        bus.start_i = 1'b1;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        for (int cy = 1; cy <= TD; cy++) begin
          bus.start_i = ($urandom_range(0, 3) == 0);
          rst = (cy == kill);
          @(posedge clk);
          #1 rst = 1'b0;
          if (cy == kill) break;
        end
        bus.start_i = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
      repeat (TD + 4) @(posedge clk);
      fin = 1;
    end
  end
  initial begin
    int k;
    k = 0;
    while (!(c[0].fin && c[1].fin && c[2].fin && c[3].fin) && k < 40000) begin
      @(posedge clk);
      k++;
    end
    if (k >= 40000) chk(-1, "timeout", 0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
